div_radix2: RTL

DIV_RADIX2 -- requirements
Module: div_radix2

---
 rtl/div_radix2.sv | 124 ++++++++++++
 1 files changed

// File: rtl/div_radix2.sv
// Radix-2 restoring divider for the EX stage.
// Signed/unsigned 32/32 divide, 32 BUSY cycles per divide.
// Result is {remainder, quotient}. Divide by zero finishes in one cycle.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic        hold,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // {partial remainder[64:32], dividend/quotient[31:0]}
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        sign1, sign2;
  logic [31:0] abs1, abs2;
  logic [64:0] shifted;
  logic [33:0] diff;
  logic [64:0] step_work;
  logic [31:0] quot_fix, rem_fix;

  // Operand magnitudes and one restoring shift-subtract step.
  always_comb begin
    sign1     = signed_div & opdata1[31];
    sign2     = signed_div & opdata2[31];
    abs1      = sign1 ? (32'd0 - opdata1) : opdata1;
    abs2      = sign2 ? (32'd0 - opdata2) : opdata2;
    shifted   = {work_q[63:0], 1'b0};
    // Extra top bit keeps the borrow visible regardless of remainder width.
    diff      = {1'b0, shifted[64:32]} - {2'b00, divisor_q};
    step_work = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
    quot_fix  = qsign_q ? (32'd0 - step_work[31:0]) : step_work[31:0];
    rem_fix   = rsign_q ? (32'd0 - step_work[63:32]) : step_work[63:32];
  end

  // Next-state logic; annul wins over start and hold in every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (start && !annul) begin
          if (opdata2 == 32'd0) begin
            result_d = {opdata1, 32'hFFFF_FFFF};
            state_d  = StDone;
          end else begin
            work_d    = {33'd0, abs1};
            divisor_d = abs2;
            qsign_d   = sign1 ^ sign2;
            rsign_d   = sign1;
            cnt_d     = 5'd0;
            state_d   = StBusy;
          end
        end
      end
      StBusy: begin
        if (annul) begin
          state_d = StIdle;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = {rem_fix, quot_fix};
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        // start is ignored here so a stalled divide never restarts.
        if (annul || !hold) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StDone);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule
